jtag_shift_engine: RTL and testbench

- JTAG initiator that produces the shift_tck/shift_tms/shift_tdi signals io_controller routes to the mote in modes 2 and 3, and captures mote_tdo.
- Accepts one shift command: up to MAX_BITS paired TMS/TDI bits, shifted LSB first.
- Generates TCK with a programmable divider and returns the captured TDO word with a one-cycle response pulse.
- Sits between the host command logic and io_controller.

---
 rtl/jtag_shift_engine.sv | 174 +++++++++++++++++
 tb/tb_jtag_shift_engine.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_shift_engine.sv
// JTAG shift initiator: clocks up to MAX_BITS paired TMS/TDI bits out LSB first on a
// divided TCK, captures TDO on each rising TCK edge and returns the word with a one-cycle pulse.
module jtag_shift_engine #(
  parameter int MAX_BITS = 32,
  parameter int LEN_W    = 6,
  parameter int CLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [MAX_BITS-1:0] cmd_tms,
  input  logic [MAX_BITS-1:0] cmd_tdi,
  input  logic                mote_tdo,
  output logic                shift_tck,
  output logic                shift_tms,
  output logic                shift_tdi,
  output logic                rsp_valid,
  output logic [MAX_BITS-1:0] rsp_tdo,
  output logic                busy
);

  localparam int                 CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [LEN_W-1:0]    last_q, last_d;
  logic [MAX_BITS-1:0] tms_lat_q, tms_lat_d;
  logic [MAX_BITS-1:0] tdi_lat_q, tdi_lat_d;
  logic                tck_q, tck_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [MAX_BITS-1:0] rsp_tdo_q, rsp_tdo_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic [LEN_W-1:0]    len_eff;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_MAX) begin
      return LEN_MAX;
    end
    return len;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    last_d      = last_q;
    tms_lat_d   = tms_lat_q;
    tdi_lat_d   = tdi_lat_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    rsp_valid_d = 1'b0;
    rsp_tdo_d   = rsp_tdo_q;
    len_eff     = clamp_len(cmd_len);

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rsp_tdo_d = '0;
          // A zero-length command completes on its accept edge without touching the pins
          if (len_eff == '0) begin
            rsp_valid_d = 1'b1;
          end else begin
            state_d   = LOW;
            cnt_d     = CNT_LOAD;
            idx_d     = '0;
            last_d    = len_eff - LEN_W'(1);
            tms_lat_d = cmd_tms;
            tdi_lat_d = cmd_tdi;
            tms_d     = cmd_tms[0];
            tdi_d     = cmd_tdi[0];
            tck_d     = 1'b0;
          end
        end
      end

      LOW: begin
        if (cnt_q == '0) begin
          tck_d     = 1'b1;
          rsp_tdo_d = rsp_tdo_q | (MAX_BITS'(mote_tdo) << idx_q);
          cnt_d     = CNT_LOAD;
          state_d   = HIGH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      HIGH: begin
        if (cnt_q == '0) begin
          tck_d = 1'b0;
          cnt_d = CNT_LOAD;
          // TMS/TDI advance only together with the falling TCK edge
          if (idx_q != last_q) begin
            idx_d     = idx_q + LEN_W'(1);
            tms_lat_d = tms_lat_q >> 1;
            tdi_lat_d = tdi_lat_q >> 1;
            tms_d     = tms_lat_d[0];
            tdi_d     = tdi_lat_d[0];
            state_d   = LOW;
          end else begin
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tdo_q   <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tdo_q   <= rsp_tdo_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Latched command vectors are pure data and are always reloaded on accept
  always_ff @(posedge clk) begin
    tms_lat_q <= tms_lat_d;
    tdi_lat_q <= tdi_lat_d;
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign shift_tck = tck_q;
  assign shift_tms = tms_q;
  assign shift_tdi = tdi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_tdo   = rsp_tdo_q;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Bench for jtag_shift_engine: vector table plus back-to-back and reset-abort sequences,
// with a response scoreboard checking captured TDO and completion latency.
module tb_jtag_shift_engine;

  localparam int MAX_BITS = 32;
  localparam int LEN_W    = 6;
  localparam int CLK_DIV  = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [LEN_W-1:0]    cmd_len = '0;
  logic [MAX_BITS-1:0] cmd_tms = '0;
  logic [MAX_BITS-1:0] cmd_tdi = '0;
  logic                mote_tdo;
  logic                shift_tck, shift_tms, shift_tdi;
  logic                rsp_valid;
  logic [MAX_BITS-1:0] rsp_tdo;
  logic                busy;

  jtag_shift_engine #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi), .mote_tdo(mote_tdo),
    .shift_tck(shift_tck), .shift_tms(shift_tms), .shift_tdi(shift_tdi),
    .rsp_valid(rsp_valid), .rsp_tdo(rsp_tdo), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tdo;
    int          due;
  } sb_t;

  typedef struct {
    logic [5:0]  len;
    logic [31:0] tms;
    logic [31:0] tdi;
    logic [31:0] pat;
    bit          lp;
    logic [31:0] exp_tdo;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        vecs[8];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          bit_i = 0;
  int          tck_rises = 0;
  int          high_len = 0;
  bit          hold_bad = 1'b0;
  bit          chk_en = 1'b0;
  bit          loop_mode = 1'b0;
  logic [31:0] tdo_pat = '0;
  logic [31:0] cap_tms = '0;
  logic [31:0] cap_tdi = '0;
  logic        tck_prev = 1'b0;
  logic        tms_at_rise = 1'b0;
  logic        tdi_at_rise = 1'b0;

  always_ff @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] lmask(int l);
    if (l >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << l) - 32'd1;
  endfunction

  // Mote model and output monitor, sampled on the falling clk edge
  initial begin
    mote_tdo = 1'b0;
    forever begin
      @(negedge clk);
      if (busy !== 1'b1) bit_i = 0;
      if (shift_tck === 1'b1 && tck_prev === 1'b0) begin
        tck_rises++;
        if (bit_i == 0) begin
          cap_tms = '0;
          cap_tdi = '0;
        end
        cap_tms[bit_i[4:0]] = shift_tms;
        cap_tdi[bit_i[4:0]] = shift_tdi;
        tms_at_rise = shift_tms;
        tdi_at_rise = shift_tdi;
        high_len = 1;
        hold_bad = 1'b0;
        bit_i++;
      end else if (shift_tck === 1'b1) begin
        high_len++;
        if (shift_tms !== tms_at_rise || shift_tdi !== tdi_at_rise) hold_bad = 1'b1;
      end
      if (shift_tck === 1'b0 && tck_prev === 1'b1 && chk_en) begin
        chk("tck_high_len", high_len, CLK_DIV);
        chk("tms_tdi_stable_while_tck_high", {31'd0, hold_bad}, 32'd0);
      end
      mote_tdo = loop_mode ? shift_tdi : tdo_pat[bit_i[4:0]];
      if (rsp_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp_valid", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("rsp_tdo", rsp_tdo, e.tdo);
          chk("rsp_latency_cycle", cyc, e.due);
        end
      end
      tck_prev = shift_tck;
    end
  end

  task automatic send(input logic [5:0] len, input logic [31:0] tms, input logic [31:0] tdi,
                      input logic [31:0] exp, output bit with_rsp);
    int n;
    int leff;
    n = 0;
    with_rsp = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_tms   = tms;
    cmd_tdi   = tdi;
    while (cmd_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      chk("cmd_ready_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    with_rsp = (rsp_valid === 1'b1);
    @(posedge clk);
    #1;
    leff = (int'(len) > MAX_BITS) ? MAX_BITS : int'(len);
    sb_q.push_back('{exp, cyc + 2 * CLK_DIV * leff});
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("rsp_timeout_pending", sb_q.size(), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   r0;
    int   leff;
    bit   w;
    logic tms_b, tdi_b;
    tdo_pat   = v.pat;
    loop_mode = v.lp;
    r0    = tck_rises;
    tms_b = shift_tms;
    tdi_b = shift_tdi;
    leff  = (int'(v.len) > MAX_BITS) ? MAX_BITS : int'(v.len);
    send(v.len, v.tms, v.tdi, v.exp_tdo, w);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("tck_pulse_count", tck_rises - r0, leff);
    chk("rsp_tdo_held", rsp_tdo, v.exp_tdo);
    chk("idle_tck_low", {31'd0, shift_tck}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    if (leff > 0) begin
      chk("tms_sequence", cap_tms, v.tms & lmask(leff));
      chk("tdi_sequence", cap_tdi, v.tdi & lmask(leff));
      chk("idle_tms_holds_last", {31'd0, shift_tms}, {31'd0, v.tms[leff-1]});
      chk("idle_tdi_holds_last", {31'd0, shift_tdi}, {31'd0, v.tdi[leff-1]});
    end else begin
      chk("len0_tms_unchanged", {31'd0, shift_tms}, {31'd0, tms_b});
      chk("len0_tdi_unchanged", {31'd0, shift_tdi}, {31'd0, tdi_b});
    end
  endtask

  initial begin
    int   r0;
    int   n;
    int   rises;
    bit   w;
    logic prev;

    vecs[0] = '{6'd5,  32'h0000_0013, 32'h0000_000A, 32'h0000_000D, 1'b0, 32'h0000_000D};
    vecs[1] = '{6'd32, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{6'd8,  32'h0000_00FF, 32'h0000_00A5, 32'hFFFF_FF3C, 1'b0, 32'h0000_003C};
    vecs[3] = '{6'd1,  32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0001};
    vecs[4] = '{6'd0,  32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
    vecs[5] = '{6'd33, 32'h0F0F_0F0F, 32'h8765_4321, 32'h0000_0000, 1'b1, 32'h8765_4321};
    vecs[6] = '{6'd63, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
    vecs[7] = '{6'd3,  32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 1'b0, 32'h0000_0000};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_tck", {31'd0, shift_tck}, 32'd0);
      chk("rst_tms", {31'd0, shift_tms}, 32'd1);
      chk("rst_tdi", {31'd0, shift_tdi}, 32'd0);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_tdo", rsp_tdo, 32'd0);
    end

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Second command held valid while busy: accepted in the response cycle, clamped to 32
    loop_mode = 1'b1;
    r0 = tck_rises;
    send(6'd6, 32'h0000_003F, 32'h0000_002D, 32'h0000_002D, w);
    send(6'd40, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, w);
    chk("b2b_accept_in_rsp_cycle", {31'd0, w}, 32'd1);
    chk("b2b_busy_after_accept", {31'd0, busy}, 32'd1);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("b2b_tck_pulse_count", tck_rises - r0, 32'd38);
    chk("b2b_rsp_tdo_held", rsp_tdo, 32'h1234_5678);

    // Reset during the third TCK-high phase of a len=8 command
    loop_mode = 1'b0;
    tdo_pat   = 32'hFFFF_FFFF;
    send(6'd8, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, w);
    n = 0;
    rises = 0;
    prev = 1'b0;
    while (rises < 3 && n < 200) begin
      @(posedge clk);
      #1;
      if (shift_tck === 1'b1 && prev === 1'b0) rises++;
      prev = shift_tck;
      n++;
    end
    chk("abort_reached_third_high", rises, 32'd3);
    chk_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();
    chk("abort_tck", {31'd0, shift_tck}, 32'd0);
    chk("abort_tms", {31'd0, shift_tms}, 32'd1);
    chk("abort_tdi", {31'd0, shift_tdi}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_rsp_tdo", rsp_tdo, 32'd0);
    r0 = tck_rises;
    repeat (40) @(negedge clk);
    chk("abort_no_tck_after", tck_rises - r0, 32'd0);
    chk_en = 1'b1;
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
